// File: rtl/timer_bank_if.sv
// Register bus of timer_bank: word address, write strobe, write data and
// combinational read data. The timer drives rdata through the slave modport.
interface timer_bank_if #(
  parameter int NUM_TIMERS = 2
);
  localparam int CHW = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

  logic [CHW+1:0] addr;
  logic           we;
  logic [31:0]    wdata;
  logic [31:0]    rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_bank.sv
// Bank of NUM_TIMERS down-counting timers, each with CTRL/PRESET/COUNT/STATUS registers.
// Defining TIMER_PRESCALE_EN adds an 8-bit per-channel tick prescaler programmed via CTRL[15:8].
module timer_bank #(
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  timer_bank_if.slave           bus,
  output logic [NUM_TIMERS-1:0] irq
);
  localparam int CHW = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

  typedef enum logic [1:0] {IDLE, CNT, INT} state_e;

  logic [CHW-1:0] chSel;
  logic [31:0]    chRdata [NUM_TIMERS];
  logic           unused_bits;

  assign chSel       = bus.addr[CHW+1:2];
  assign unused_bits = ^bus.wdata;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
    state_e           state_q, state_d;
    logic             en_q, en_d, mode_q, mode_d, im_q, im_d, pend_q, pend_d;
    logic [WIDTH-1:0] preset_q, preset_d, count_q, count_d;
    logic [7:0]       psField;
    logic             tick, hit, wrCtrl, wrPreset, wrStatus, pendSet;
    logic [31:0]      rd;

    assign hit      = bus.we && (chSel == CHW'(i));
    assign wrCtrl   = hit && (bus.addr[1:0] == 2'd0);
    assign wrPreset = hit && (bus.addr[1:0] == 2'd1);
    assign wrStatus = hit && (bus.addr[1:0] == 2'd3);

`ifdef TIMER_PRESCALE_EN
    logic [7:0] ps_q, ps_d, psc_q, psc_d;

    assign psField = ps_q;
    assign tick    = (psc_q == ps_q);
`else
    assign psField = 8'h00;
    assign tick    = 1'b1;
`endif

    always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      preset_d = preset_q;
      count_d  = count_q;
      pend_d   = pend_q;
      pendSet  = 1'b0;
`ifdef TIMER_PRESCALE_EN
      ps_d     = ps_q;
      psc_d    = psc_q;
`endif
      case (state_q)
        IDLE: begin
          if (en_q) begin
            count_d = preset_q;
            state_d = CNT;
`ifdef TIMER_PRESCALE_EN
            psc_d   = 8'h00;
`endif
          end
        end
        CNT: begin
`ifdef TIMER_PRESCALE_EN
          psc_d = tick ? 8'h00 : psc_q + 8'h01;
`endif
          // A final count of 1 or 0 both expire, so PRESET=0 behaves like PRESET=1.
          if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              count_d = '0;
              pendSet = 1'b1;
              state_d = INT;
            end
          end
        end
        INT: begin
          if (mode_q) begin
            count_d = preset_q;
            state_d = CNT;
`ifdef TIMER_PRESCALE_EN
            psc_d   = 8'h00;
`endif
          end else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (wrCtrl) begin
        en_d   = bus.wdata[0];
        mode_d = bus.wdata[1];
        im_d   = bus.wdata[3];
`ifdef TIMER_PRESCALE_EN
        ps_d   = bus.wdata[15:8];
`endif
        // Disabling aborts the channel on this very edge and freezes COUNT.
        if (!bus.wdata[0]) begin
          state_d = IDLE;
          count_d = count_q;
          pendSet = 1'b0;
        end
      end
      if (wrPreset) preset_d = bus.wdata[WIDTH-1:0];
      if (wrStatus && bus.wdata[0]) pend_d = 1'b0;
      if (pendSet) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= IDLE;
        en_q     <= 1'b0;
        mode_q   <= 1'b0;
        im_q     <= 1'b0;
        preset_q <= '0;
        count_q  <= '0;
        pend_q   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
        ps_q     <= 8'h00;
        psc_q    <= 8'h00;
`endif
      end else begin
        state_q  <= state_d;
        en_q     <= en_d;
        mode_q   <= mode_d;
        im_q     <= im_d;
        preset_q <= preset_d;
        count_q  <= count_d;
        pend_q   <= pend_d;
`ifdef TIMER_PRESCALE_EN
        ps_q     <= ps_d;
        psc_q    <= psc_d;
`endif
      end
    end

    always_comb begin
      rd = '0;
      case (bus.addr[1:0])
        2'd0:    rd[15:0]      = {psField, 4'h0, im_q, 1'b0, mode_q, en_q};
        2'd1:    rd[WIDTH-1:0] = preset_q;
        2'd2:    rd[WIDTH-1:0] = count_q;
        default: rd[0]         = pend_q;
      endcase
    end

    assign chRdata[i] = rd;
    assign irq[i]     = pend_q & im_q;
  end

  // Channel indices with no timer behind them fall through to zero.
  always_comb begin
    bus.rdata = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (chSel == CHW'(i)) bus.rdata = chRdata[i];
    end
  end
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank with 6 channels and 16-bit counters: directed scenarios, then
// randomized channel programs checked against closed-form COUNT/irq timing.
module tb_timer_bank;
  localparam int NT = 6;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NT-1:0] irq;
  int            errors  = 0;
  int            checks  = 0;
  int            edgeNum = 0;
  int            rP [NT];
  int            rMode [NT];
  int            rIm [NT];
  int            rPs [NT];
  int            rLoad [NT];
  int            fireAt [NT];
  logic [NT-1:0] expMask;

  timer_bank_if #(.NUM_TIMERS(NT)) bus ();

  timer_bank #(.NUM_TIMERS(NT), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #10 clk = ~clk;

  task automatic nextEdge();
    @(posedge clk);
    edgeNum++;
    #1;
  endtask

  task automatic applyStimulus(input int ch, input int regIdx, input logic [31:0] data);
    bus.addr  = {3'(ch), 2'(regIdx)};
    bus.we    = 1'b1;
    bus.wdata = data;
    nextEdge();
    bus.we    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input string tag, input int ch, input int regIdx, input logic [31:0] expected);
    bus.addr = {3'(ch), 2'(regIdx)};
    #1;
    checkOutput(tag, bus.rdata, expected);
  endtask

  // Timing model: after a load, a tick lands every PS+1 cycles, expiry after max(P,1) ticks,
  // and auto-reload repeats with period 1 + (PS+1)*max(P,1).
  task automatic checkModel(input string tag);
    logic [NT-1:0] expIrq;
    expIrq = '0;
    for (int c = 0; c < NT; c++) begin
      int k, step, pe, period, j, cnt;
      k = edgeNum - rLoad[c];
      if (k < 0) continue;
      step   = rPs[c] + 1;
      pe     = (rP[c] == 0) ? 1 : rP[c];
      period = 1 + step * pe;
      if (rMode[c] == 1) j = k % period;
      else               j = (k < period) ? k : period - 1;
      cnt = rP[c] - j / step;
      if (cnt < 0) cnt = 0;
      checkReg({tag, " count"}, c, 2, 32'(cnt));
      if (k >= period - 1 && rIm[c] == 1) expIrq[c] = 1'b1;
    end
    checkOutput({tag, " irq"}, 32'(irq), 32'(expIrq));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    repeat (2) nextEdge();
    checkOutput("reset irq", 32'(irq), 32'h0);
    for (int r = 0; r < 4; r++) checkReg("reset ch0", 0, r, 32'h0);
    rst = 1'b1;
    nextEdge();

    // One-shot on channel 0, with PRESET bits above WIDTH ignored and COUNT read-only.
    applyStimulus(0, 1, 32'hABCD0005);
    checkReg("preset width", 0, 1, 32'h5);
    applyStimulus(0, 2, 32'h7);
    checkReg("count readonly", 0, 2, 32'h0);
    applyStimulus(0, 0, 32'h9);
    checkReg("ctrl readback", 0, 0, 32'h9);
    checkReg("count at E", 0, 2, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      nextEdge();
      checkReg("oneshot count", 0, 2, 32'(6 - k));
      checkOutput("oneshot irq quiet", 32'(irq), 32'h0);
    end
    nextEdge();
    checkReg("oneshot count E+6", 0, 2, 32'h0);
    checkReg("oneshot pend E+6", 0, 3, 32'h1);
    checkOutput("oneshot irq E+6", 32'(irq), 32'h1);
    nextEdge();
    checkReg("oneshot ctrl E+7", 0, 0, 32'h8);
    nextEdge();
    checkReg("oneshot idle count", 0, 2, 32'h0);
    applyStimulus(0, 3, 32'h0);
    checkReg("status write0", 0, 3, 32'h1);
    applyStimulus(0, 3, 32'h1);
    checkReg("status clear", 0, 3, 32'h0);
    checkOutput("irq after clear", 32'(irq), 32'h0);

    // Auto-reload on channel 1, clearing PEND the edge after each interrupt.
    applyStimulus(1, 1, 32'h5);
    applyStimulus(1, 0, 32'hB);
    for (int k = 1; k <= 19; k++) begin
      if (k % 6 == 1 && k > 1) applyStimulus(1, 3, 32'h1);
      else nextEdge();
      checkOutput("autoreload irq", 32'(irq), (k % 6 == 0) ? 32'h2 : 32'h0);
    end
    applyStimulus(1, 0, 32'h0);

    // Masking and set/clear collision on channel 2.
    applyStimulus(2, 1, 32'h2);
    applyStimulus(2, 0, 32'h3);
    repeat (3) nextEdge();
    checkReg("masked pend", 2, 3, 32'h1);
    checkOutput("masked irq", 32'(irq), 32'h0);
    applyStimulus(2, 3, 32'h1);
    checkReg("masked clear", 2, 3, 32'h0);
    nextEdge();
    applyStimulus(2, 3, 32'h1);
    checkReg("collision pend", 2, 3, 32'h1);
    applyStimulus(2, 0, 32'hB);
    checkOutput("unmask irq", 32'(irq), 32'h4);
    applyStimulus(2, 0, 32'h8);
    checkReg("abort keeps pend", 2, 3, 32'h1);
    checkOutput("abort keeps irq", 32'(irq), 32'h4);
    applyStimulus(2, 3, 32'h1);
    checkOutput("ch2 cleared irq", 32'(irq), 32'h0);

    // Abort by EN=0 while COUNT reads 3 on channel 3.
    applyStimulus(3, 1, 32'h6);
    applyStimulus(3, 0, 32'h9);
    repeat (4) nextEdge();
    checkReg("abort pre count", 3, 2, 32'h3);
    applyStimulus(3, 0, 32'h8);
    checkReg("abort hold", 3, 2, 32'h3);
    repeat (10) nextEdge();
    checkReg("abort hold later", 3, 2, 32'h3);
    checkReg("abort ctrl", 3, 0, 32'h8);
    checkReg("abort no pend", 3, 3, 32'h0);
    checkOutput("abort irq", 32'(irq), 32'h0);

    // Asynchronous reset in the middle of a count on channel 4.
    applyStimulus(4, 1, 32'hA);
    applyStimulus(4, 0, 32'h9);
    repeat (3) nextEdge();
    checkReg("pre-reset count", 4, 2, 32'h8);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async reset irq", 32'(irq), 32'h0);
    for (int c = 0; c < NT; c++)
      for (int r = 0; r < 4; r++) checkReg("async reset reg", c, r, 32'h0);
    rst = 1'b1;
    repeat (12) nextEdge();
    checkReg("post-reset count", 4, 2, 32'h0);
    checkReg("post-reset ctrl", 4, 0, 32'h0);
    checkOutput("post-reset irq", 32'(irq), 32'h0);

    // All channels with presets 1..6, each expiring on its own edge.
    for (int c = 0; c < NT; c++) begin
      fireAt[c] = 1000000;
      applyStimulus(c, 1, 32'(c + 1));
    end
    for (int c = 0; c < NT + 15; c++) begin
      if (c < NT) begin
        applyStimulus(c, 0, 32'h9);
        fireAt[c] = edgeNum + 1 + (c + 1);
      end else begin
        nextEdge();
      end
      expMask = '0;
      for (int t = 0; t < NT; t++) if (edgeNum >= fireAt[t]) expMask[t] = 1'b1;
      checkOutput("multi irq", 32'(irq), 32'(expMask));
    end
    checkReg("channel 7 read", 7, 0, 32'h0);
    checkReg("channel 6 read", 6, 3, 32'h0);
    applyStimulus(7, 0, 32'h9);
    checkReg("channel 7 write ignored", 7, 0, 32'h0);
    checkOutput("irq after ch7 write", 32'(irq), 32'h3F);
    for (int c = 0; c < NT; c++) applyStimulus(c, 3, 32'h1);

`ifdef TIMER_PRESCALE_EN
    applyStimulus(0, 1, 32'h2);
    applyStimulus(0, 0, 32'h309);
    checkReg("prescale ctrl", 0, 0, 32'h309);
    repeat (4) nextEdge();
    checkReg("prescale count E+4", 0, 2, 32'h2);
    nextEdge();
    checkReg("prescale count E+5", 0, 2, 32'h1);
    repeat (3) nextEdge();
    checkReg("prescale pend E+8", 0, 3, 32'h0);
    nextEdge();
    checkReg("prescale pend E+9", 0, 3, 32'h1);
    applyStimulus(0, 3, 32'h1);
`else
    applyStimulus(0, 0, 32'h308);
    checkReg("no prescaler field", 0, 0, 32'h8);
    applyStimulus(0, 0, 32'h0);
`endif

    // Randomized programs on every channel.
    for (int round = 0; round < 3; round++) begin
      for (int c = 0; c < NT; c++) begin
        rLoad[c] = 1000000;
        applyStimulus(c, 0, 32'h0);
      end
      for (int c = 0; c < NT; c++) applyStimulus(c, 3, 32'h1);
      for (int c = 0; c < NT; c++) begin
        rP[c]    = $urandom_range(0, 9);
        rMode[c] = $urandom_range(0, 1);
        rIm[c]   = $urandom_range(0, 1);
`ifdef TIMER_PRESCALE_EN
        rPs[c]   = $urandom_range(0, 3);
`else
        rPs[c]   = 0;
`endif
        applyStimulus(c, 1, {16'($urandom), 16'(rP[c])});
        checkModel("rand idle");
      end
      for (int c = 0; c < NT; c++) begin
        applyStimulus(c, 0, 32'(1 | (rMode[c] << 1) | (rIm[c] << 3) | (rPs[c] << 8)));
        rLoad[c] = edgeNum + 1;
        checkModel("rand start");
      end
      repeat (40) begin
        nextEdge();
        checkModel("rand run");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
